parity_frame_tx: RTL and testbench

Serialises the 4-bit data nibble and the parity bit produced by `parity_generator` into a framed single-wire bit stream: start bit, four data bits LSB first, parity bit, stop bit. It sits directly downstream of the parity generator. It accepts one nibble per frame through a valid/ready handshake and flags any nibble whose supplied parity disagrees with even parity.

---
 rtl/parity_pkg.sv | 24 ++
 rtl/parity_frame_tx_if.sv | 19 +
 rtl/bit_timer.sv | 32 +++
 rtl/parity_frame_tx.sv | 128 ++++++++++++
 tb/tb_parity_frame_tx.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/parity_pkg.sv
// parity_pkg
// Shared types and constants for the parity frame transmitter.
//   tx_state_t  : transmitter FSM states
//   DATA_W      : width of the transmitted nibble
//   FRAME_BITS  : start + data + parity + stop bits per frame
//   even_parity : parity bit an even-parity source should supply for a nibble
package parity_pkg;

  localparam int DATA_W     = 4;
  localparam int FRAME_BITS = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/parity_frame_tx_if.sv
// parity_frame_tx_if
// Valid/ready handshake carrying one nibble plus its parity bit.
//   data   : nibble to transmit
//   parity : parity bit supplied by the upstream generator
//   valid  : data/parity valid this cycle
//   ready  : downstream can accept a nibble
// master = upstream producer, slave = parity_frame_tx.
interface parity_frame_tx_if;
  import parity_pkg::*;

  logic [DATA_W-1:0] data;
  logic              parity;
  logic              valid;
  logic              ready;

  modport master (output data, output parity, output valid, input ready);
  modport slave  (input data, input parity, input valid, output ready);

endinterface

// File: rtl/bit_timer.sv
// bit_timer
// Divides the clock into bit periods of CLKS_PER_BIT cycles.
//   clk  : clock
//   rst  : synchronous active-high reset
//   en   : count while high, held at zero while low
//   tick : high in the last cycle of each bit period
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  // A single-cycle bit period still needs a one-bit counter.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Wrapping on tick restarts the count for the next frame bit.
  always_ff @(posedge clk) begin
    if (rst || !en || tick)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/parity_frame_tx.sv
// parity_frame_tx
// Serialises a nibble and its supplied parity bit into a framed bit stream:
// start (0), four data bits LSB first, parity, stop (1).
//   clk        : clock
//   rst        : synchronous active-high reset
//   up         : valid/ready handshake (slave side) delivering data + parity
//   tx         : registered serial line, idles at 1
//   busy       : frame in progress
//   done       : one-cycle pulse in the first idle cycle after a frame
//   parity_err : supplied parity disagreed with even parity, held until next accept
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  parity_frame_tx_if.slave   up,
  output logic               tx,
  output logic               busy,
  output logic               done,
  output logic               parity_err
);

  tx_state_t         state, state_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [1:0]        bitcnt, bitcnt_n;
  logic              par_q, par_n;
  logic              perr_n;
  logic              tx_n;
  logic              done_n;
  logic              tick;

  assign up.ready = (state == IDLE);
  assign busy     = (state != IDLE);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .tick (tick)
  );

  // State and output registers. tx is computed one cycle ahead so the line
  // changes on the same edge as the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      bitcnt     <= '0;
      par_q      <= 1'b0;
      tx         <= 1'b1;
      done       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      bitcnt     <= bitcnt_n;
      par_q      <= par_n;
      tx         <= tx_n;
      done       <= done_n;
      parity_err <= perr_n;
    end
  end

  // Next-state logic. A parity mismatch is only flagged; the supplied bit is
  // still transmitted and the frame runs to completion.
  always_comb begin
    state_n  = state;
    shift_n  = shift;
    bitcnt_n = bitcnt;
    par_n    = par_q;
    perr_n   = parity_err;
    tx_n     = tx;
    done_n   = 1'b0;

    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (up.valid) begin
          shift_n  = up.data;
          par_n    = up.parity;
          perr_n   = (up.parity != even_parity(up.data));
          bitcnt_n = '0;
          state_n  = START;
          tx_n     = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          tx_n    = shift[0];
        end
      end
      DATA: begin
        if (tick) begin
          shift_n = shift >> 1;
          if (bitcnt == 2'd3) begin
            bitcnt_n = '0;
            state_n  = PARITY;
            tx_n     = par_q;
          end else begin
            bitcnt_n = bitcnt + 2'd1;
            tx_n     = shift[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          state_n = IDLE;
          tx_n    = 1'b1;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb_parity_frame_tx
// Self-checking bench for parity_frame_tx. Two instances share clk/rst:
// one with CLKS_PER_BIT=4 and one with CLKS_PER_BIT=1; `sel` picks which
// one the stimulus and frame-collection tasks talk to. Expected frames are
// built from the nibble/parity driven and queued at accept, then popped
// when the frame appears on tx.
module tb_parity_frame_tx;
  import parity_pkg::*;

  typedef struct {
    logic [FRAME_BITS-1:0] bits;
    logic                  perr;
  } frame_t;

  logic clk;
  logic rst;
  logic sel;

  logic tx4, busy4, done4, perr4;
  logic tx1, busy1, done1, perr1;

  int total = 0;
  int bad   = 0;

  frame_t sb[$];

  parity_frame_tx_if bus4 ();
  parity_frame_tx_if bus1 ();

  parity_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .up         (bus4),
    .tx         (tx4),
    .busy       (busy4),
    .done       (done4),
    .parity_err (perr4)
  );

  parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .up         (bus1),
    .tx         (tx1),
    .busy       (busy1),
    .done       (done1),
    .parity_err (perr1)
  );

  logic txS, busyS, doneS, perrS, readyS;
  assign txS    = sel ? tx1        : tx4;
  assign busyS  = sel ? busy1      : busy4;
  assign doneS  = sel ? done1      : done4;
  assign perrS  = sel ? perr1      : perr4;
  assign readyS = sel ? bus1.ready : bus4.ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit");
  end

  // Frame as it should appear on tx: start 0, data LSB first, parity, stop 1.
  function automatic frame_t makeFrame(input logic [3:0] d, input logic p);
    frame_t f;
    f.bits = {1'b1, p, d, 1'b0};
    f.perr = (p != (d[0] ^ d[1] ^ d[2] ^ d[3]));
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic setValid(input logic v);
    if (sel) bus1.valid = v;
    else     bus4.valid = v;
  endtask

  // Presents a nibble and waits for the handshake; returns just after the
  // accepting edge with the expected frame queued.
  task automatic applyStimulus(input logic [3:0] d, input logic p, input bit hold);
    int waitCnt = 0;
    @(negedge clk);
    if (sel) begin
      bus1.data = d; bus1.parity = p;
    end else begin
      bus4.data = d; bus4.parity = p;
    end
    setValid(1'b1);
    while (!readyS && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 200) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      setValid(1'b0);
      return;
    end
    @(posedge clk);
    #1;
    sb.push_back(makeFrame(d, p));
    if (!hold) setValid(1'b0);
  endtask

  // Waits for the start bit, then checks every cycle of the frame and the
  // done pulse that follows. gap >= 0 also checks the number of idle
  // samples seen before the start bit.
  task automatic collectFrame(input int gap);
    int     idle = 0;
    int     cpb;
    frame_t exp;
    cpb = sel ? 1 : 4;
    @(negedge clk);
    while (txS !== 1'b0 && idle < 200) begin
      idle++;
      @(negedge clk);
    end
    if (idle >= 200) begin
      checkOutput("start_timeout", 32'd0, 32'd1);
      return;
    end
    if (gap >= 0) checkOutput("gap", idle, gap);
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", 32'd0, 32'd1);
      return;
    end
    exp = sb.pop_front();
    checkOutput("parity_err", perrS, exp.perr);
    for (int k = 0; k < FRAME_BITS * cpb; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput($sformatf("tx_slot%0d", k / cpb), txS, exp.bits[k / cpb]);
      checkOutput("busy_in_frame", busyS, 1'b1);
      checkOutput("done_early", doneS, 1'b0);
    end
    @(negedge clk);
    checkOutput("done", doneS, 1'b1);
    checkOutput("tx_after", txS, 1'b1);
    checkOutput("busy_after", busyS, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    bus4.valid = 1'b0; bus4.data = '0; bus4.parity = 1'b0;
    bus1.valid = 1'b0; bus1.data = '0; bus1.parity = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_tx4",    tx4,        1'b1);
    checkOutput("rst_busy4",  busy4,      1'b0);
    checkOutput("rst_done4",  done4,      1'b0);
    checkOutput("rst_perr4",  perr4,      1'b0);
    checkOutput("rst_ready4", bus4.ready, 1'b1);
    checkOutput("rst_tx1",    tx1,        1'b1);
    checkOutput("rst_busy1",  busy1,      1'b0);
    checkOutput("rst_ready1", bus1.ready, 1'b1);
    rst = 1'b0;

    // Good parity frame.
    applyStimulus(4'b1011, 1'b1, 1'b0);
    collectFrame(-1);

    // Wrong parity: flagged, still transmitted, flag held afterwards.
    applyStimulus(4'b0001, 1'b0, 1'b0);
    collectFrame(-1);
    checkOutput("perr_held", perrS, 1'b1);

    // Back-to-back with valid held high: second nibble taken in done cycle.
    applyStimulus(4'b1100, 1'b0, 1'b1);
    bus4.data   = 4'b1101;
    bus4.parity = 1'b1;
    sb.push_back(makeFrame(4'b1101, 1'b1));
    collectFrame(-1);
    @(posedge clk);
    #1;
    bus4.valid = 1'b0;
    collectFrame(0);

    // A valid pulse during DATA must be ignored.
    applyStimulus(4'b0110, 1'b0, 1'b0);
    fork
      collectFrame(-1);
      begin
        repeat (6) @(negedge clk);
        bus4.data  = 4'b0000;
        bus4.valid = 1'b1;
        checkOutput("ready_in_data", readyS, 1'b0);
        @(negedge clk);
        bus4.valid = 1'b0;
      end
    join
    repeat (5) begin
      @(negedge clk);
      checkOutput("no_extra_frame", busyS, 1'b0);
    end
    checkOutput("sb_empty", sb.size(), 32'd0);

    // Reset during PARITY abandons the frame without a done pulse.
    applyStimulus(4'b0111, 1'b0, 1'b0);
    repeat (21) @(negedge clk);
    checkOutput("pre_rst_parity_slot", txS,  1'b0);
    checkOutput("pre_rst_perr",        perrS, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_tx",    txS,    1'b1);
    checkOutput("midrst_busy",  busyS,  1'b0);
    checkOutput("midrst_ready", readyS, 1'b1);
    checkOutput("midrst_done",  doneS,  1'b0);
    checkOutput("midrst_perr",  perrS,  1'b0);
    rst = 1'b0;
    void'(sb.pop_front());
    repeat (8) begin
      @(negedge clk);
      checkOutput("midrst_no_done", doneS, 1'b0);
      checkOutput("midrst_idle_tx", txS,   1'b1);
    end

    // Single-cycle bit period.
    sel = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    collectFrame(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
